prog_loader: RTL
================

# prog_loader

Program loader and boot sequencer for the SAP-2 mini. It receives a block of 12-bit words from a host over a valid/ready handshake and writes them into the 256×12 RAM through the memory's programming path: `prog`, a direct address and write data. It then validates a trailing checksum word. On a good checksum it pulses the CPU reset and releases the CPU to run. On a bad checksum it holds the CPU in reset and flags an error.

## Interface
Parameters:
- `RST_CYCLES`, default 2: number of cycles `cpu_clr` is held high in the RST state before the CPU is released.

Ports:
- `clk`  in  1  clock.
- `clr`  in  1  reset, asynchronous, active-high.
- `start`  in  1  begin a load. Sampled only in IDLE, DONE or ERR.
- `base`  in  8  first RAM address. Latched on start.
- `len`  in  8  word count minus 1, so 1–256 data words. Latched on start.
- `in_valid`  in  1  host word valid.
- `in_data`  in  12  host word.
- `in_ready`  out  1  loader accepts a word this cycle.
- `prog`  out  1  RAM/MAR programming-mode select.
- `addr`  out  8  RAM write address.
- `wdata`  out  12  RAM write data.
- `we`  out  1  RAM write enable, one-cycle pulse.
- `cpu_clr`  out  1  CPU clear: drives pc/ir/ctrl clr.
- `busy`  out  1  load in progress.
- `done`  out  1  load succeeded; CPU running.
- `err`  out  1  checksum mismatch.

## Operation
- **States:** IDLE, WAIT, WRITE, CHECK, RST, DONE, ERR.
- **Output decode:** all outputs are Moore-decoded from state and registers. No input-to-output combinational path.
- **IDLE**
  - `cpu_clr`=1; all other outputs 0.
  - `start` → WAIT. Latch `addr`←`base` and `remain`←`len`. Clear `sum` (12 bits).
- **WAIT**
  - `prog`=1, `busy`=1, `in_ready`=1.
  - On `in_valid`: latch `wdata`←`in_data` and set `sum`←`sum`+`in_data` (mod 4096), then → WRITE.
  - Otherwise remain in WAIT; `addr` and `wdata` hold.
- **WRITE**
  - `prog`=1, `we`=1, `busy`=1; the RAM captures `wdata` at `addr` on this cycle's edge.
  - If `remain`==0 → CHECK.
  - Otherwise `addr`←`addr`+1 (wraps 0xFF→0x00), `remain`←`remain`−1, and → WAIT.
- **CHECK**
  - `prog`=1, `busy`=1, `in_ready`=1; no RAM write.
  - On `in_valid`: if (`sum`+`in_data`) mod 4096 == 0 → RST, else → ERR.
- **RST**
  - `prog`=0, `busy`=1, `cpu_clr`=1.
  - Stays RST_CYCLES cycles, counted by a cycle counter, then → DONE.
- **DONE**
  - `done`=1, `cpu_clr`=0, `prog`=0. The CPU runs.
  - `start` → WAIT, which asserts `cpu_clr` again (reload).
- **ERR**
  - `err`=1, `cpu_clr`=1, `prog`=0.
  - `start` → WAIT (retry).
- **Ignored input:** `start` in WAIT, WRITE, CHECK or RST has no effect.
- **`cpu_clr` rule:** `cpu_clr`=1 in every state except DONE. The CPU never runs from partially loaded or unverified memory.
- **`we` rule:** `we` never asserts while `prog`=0.

## Timing
- **Reset:** `clr` forces IDLE immediately, independent of `clk`, including mid-load. Reset values:
  - `state`=IDLE, `addr`=0, `wdata`=0, `sum`=0, `remain`=0.
  - `prog`=0, `we`=0, `in_ready`=0, `busy`=0, `done`=0, `err`=0, `cpu_clr`=1.
- **Handshake:** a word transfers on a rising edge where `in_valid`=`in_ready`=1. The host may hold `in_valid` high continuously.
- **Throughput:** at most one word per 2 cycles (WAIT, WRITE).
- **Write timing:** a word accepted at edge N is written at edge N+1, with `we` high during cycle N+1. `addr` increments at edge N+1.
- **Start latency:** `start` sampled at edge S gives `prog`/`busy`/`in_ready` high from S.
- **Release latency:** a checksum accepted at edge C gives RST in cycles C..C+RST_CYCLES−1. `done`=1 and `cpu_clr`=0 from edge C+RST_CYCLES.
- **Error latency:** a bad checksum at edge C gives `err`=1 from C.
- **Full-memory load:** `len`=255 writes exactly 256 addresses starting at `base`, wrapping to cover every RAM location once.
- **Checksum arithmetic:** 12-bit, carries discarded. The checksum word is not written to RAM.

## Test plan
- **Reset values:** assert `clr` → `prog`=0, `we`=0, `in_ready`=0, `busy`=0, `done`=0, `err`=0, `cpu_clr`=1, `addr`=0. Pulse `start` with `clr` high → no state change.
- **Basic load:** `base`=0x10, `len`=2; words 0x123, 0x456, 0x789, then checksum 0x2FE, with `in_valid` held high.
  - `we` pulses at `addr` 0x10, 0x11, 0x12 with matching `wdata`, on alternate cycles.
  - `cpu_clr` stays high 2 cycles after the checksum, then `done`=1 and `cpu_clr`=0.
  - The RAM model reads back the three words.
- **Bad checksum:** same stream with checksum 0x2FF → `err`=1, `done`=0, `cpu_clr` stays 1. A new `start` followed by a good stream → `done`=1 and `err`=0.
- **Address wrap:** `base`=0xFF, `len`=1 → writes at 0xFF then 0x00. A `len`=255 load writes 256 distinct addresses.
- **Host stall:** `in_valid` low for 5 cycles mid-load → `in_ready` stays 1, `we` stays 0, `addr`/`wdata`/`sum` stable, and the load completes correctly afterward.
- **Reset mid-load:**
  - `clr` after 1 of 3 words → immediate IDLE values; a subsequent full load succeeds.
  - `start` pulsed during WAIT or WRITE → ignored.
  - `start` in DONE → `cpu_clr` rises at the sampling edge.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader and boot sequencer: streams host words into RAM through the
// programming path, verifies a trailing 12-bit checksum, then releases the CPU.
module prog_loader #(
  parameter int RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        i_start,
  input  logic [7:0]  i_base,
  input  logic [7:0]  i_len,
  input  logic        i_in_valid,
  input  logic [11:0] i_in_data,
  output logic        o_in_ready,
  output logic        o_prog,
  output logic [7:0]  o_addr,
  output logic [11:0] o_wdata,
  output logic        o_we,
  output logic        o_cpu_clr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_WRITE = 3'd2,
    S_CHECK = 3'd3,
    S_RST   = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_addr, w_addr_nxt;
  logic [11:0]   r_wdata, w_wdata_nxt;
  logic [11:0]   r_sum, w_sum_nxt;
  logic [7:0]    r_remain, w_remain_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [11:0]   w_sum_chk;

  assign w_sum_chk = r_sum + i_in_data;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;

  // State and datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_addr   <= 8'h00;
      r_wdata  <= 12'h000;
      r_sum    <= 12'h000;
      r_remain <= 8'h00;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_sum    <= w_sum_nxt;
      r_remain <= w_remain_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Next-state, datapath updates and Moore output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_sum_nxt    = r_sum;
    w_remain_nxt = r_remain;
    w_cnt_nxt    = r_cnt;
    o_in_ready   = 1'b0;
    o_prog       = 1'b0;
    o_we         = 1'b0;
    o_cpu_clr    = 1'b1;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;

    case (r_state)
      // Idle, running and failed states all accept a (re)load request.
      S_IDLE, S_DONE, S_ERR: begin
        o_done    = (r_state == S_DONE);
        o_err     = (r_state == S_ERR);
        o_cpu_clr = (r_state != S_DONE);
        if (i_start) begin
          w_state_nxt  = S_WAIT;
          w_addr_nxt   = i_base;
          w_remain_nxt = i_len;
          w_sum_nxt    = 12'h000;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_WAIT: begin
        o_prog     = 1'b1;
        o_busy     = 1'b1;
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_wdata_nxt = i_in_data;
          w_sum_nxt   = w_sum_chk;
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WRITE: begin
        o_prog = 1'b1;
        o_we   = 1'b1;
        o_busy = 1'b1;
        if (r_remain == 8'h00) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_addr_nxt   = r_addr + 8'h01;
          w_remain_nxt = r_remain - 8'h01;
          w_state_nxt  = S_WAIT;
        end
      end
      // The checksum word is only summed, never written to RAM.
      S_CHECK: begin
        o_prog     = 1'b1;
        o_busy     = 1'b1;
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          if (w_sum_chk == 12'h000) begin
            w_state_nxt = S_RST;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_ERR;
          end
        end else begin
          w_state_nxt = S_CHECK;
        end
      end
      S_RST: begin
        o_busy = 1'b1;
        if (r_cnt == CW'(RST_CYCLES - 1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
